// File: rtl/crypto_isa_pkg.sv
// Shared AES instruction-set encodings for the sequencer and control decoder.
// The AES_SEQ_PERF_EN option lives in aes_instr_sequencer.
package crypto_isa_pkg;

    typedef enum logic [6:0] {
        AES_CRYPTO = 7'b1100011,
        R_TYPE     = 7'b0110011
    } opcode_e;

    typedef enum logic [2:0] {
        aesEncryption  = 3'b000,
        keyExpandRound = 3'b001,
        aesDecryption  = 3'b010
    } aes_funct3_e;

    typedef enum logic [2:0] {
        XOR = 3'b001
    } alu_funct3_e;

    localparam logic [6:0] FINAL_FUNCT7 = 7'h01;

    typedef enum logic [1:0] {
        MODE_KEY_EXP = 2'd0,
        MODE_ENC     = 2'd1,
        MODE_DEC     = 2'd2,
        MODE_ILLEGAL = 2'd3
    } cmd_mode_e;

endpackage

// File: rtl/aes_instr_encoder.sv
// R-type field packer: funct7, rs2, rs1, funct3, rd, opcode -> 32-bit word.
module aes_instr_encoder
    import crypto_isa_pkg::*;
(
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rs1,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [6:0]  opcode,
    output logic [31:0] instr
);

    assign instr = {funct7, rs2, rs1, funct3, rd, opcode};

endmodule

// File: rtl/aes_instr_sequencer.sv
// Expands one AES command into its encoded instruction stream.
// Define AES_SEQ_PERF_EN to add the perf_stall_cnt stall counter.
module aes_instr_sequencer
    import crypto_isa_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int INSTR_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [4:0]         cmd_state_reg,
    input  logic [4:0]         cmd_key_base,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_last,
    output logic               busy,
    output logic               done,
    output logic               cmd_err
`ifdef AES_SEQ_PERF_EN
    ,
    output logic [15:0]        perf_stall_cnt
`endif
);

    localparam logic [4:0] NR5 = 5'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_e;

    state_e    state;
    cmd_mode_e mode;
    logic [4:0] state_reg;
    logic [4:0] key_base;
    logic [4:0] r;
    logic [4:0] r_inc;
    logic [4:0] last_idx;

    logic [6:0] f7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [6:0] op;
    logic [31:0] word;

    assign r_inc    = r + 5'd1;
    assign last_idx = (mode == MODE_KEY_EXP) ? NR5 - 5'd1 : NR5;

    always_comb begin
        f7  = '0;
        rs2 = key_base;
        rs1 = state_reg;
        rd  = state_reg;
        f3  = aesEncryption;
        op  = AES_CRYPTO;
        unique case (mode)
            MODE_KEY_EXP: begin
                f7  = {2'b00, r_inc};
                rs2 = key_base + r;
                rs1 = key_base + r;
                rd  = key_base + r_inc;
                f3  = keyExpandRound;
            end
            MODE_ENC: rs2 = key_base + r;
            MODE_DEC: begin
                rs2 = key_base + NR5 - r;
                f3  = aesDecryption;
            end
            default: ;
        endcase
        // Encrypt/decrypt open with the whitening XOR and close with the final round.
        if (mode != MODE_KEY_EXP) begin
            if (r == 5'd0) begin
                op = R_TYPE;
                f3 = XOR;
            end else if (r == NR5) begin
                f7 = FINAL_FUNCT7;
            end
        end
    end

    aes_instr_encoder u_enc (
        .funct7 (f7),
        .rs2    (rs2),
        .rs1    (rs1),
        .funct3 (f3),
        .rd     (rd),
        .opcode (op),
        .instr  (word)
    );

    assign instr      = instr_valid ? INSTR_W'(word) : '0;
    assign instr_last = instr_valid && (r == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode        <= MODE_KEY_EXP;
            state_reg   <= '0;
            key_base    <= '0;
            r           <= '0;
            cmd_ready   <= 1'b1;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mode      <= cmd_mode_e'(cmd_mode);
                        state_reg <= cmd_state_reg;
                        key_base  <= cmd_key_base;
                        r         <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_mode_e'(cmd_mode) == MODE_ILLEGAL) begin
                            state   <= FINISH;
                            done    <= 1'b1;
                            cmd_err <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        if (r == last_idx) begin
                            state       <= FINISH;
                            instr_valid <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            r <= r_inc;
                        end
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    cmd_err   <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if (state == IDLE && cmd_valid) begin
            perf_stall_cnt <= '0;
        end else if (instr_valid && !instr_ready && perf_stall_cnt != 16'hFFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_instr_sequencer.sv
// Scoreboard bench for aes_instr_sequencer: directed AES command streams.
module tb_aes_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [4:0]  cmd_state_reg;
    logic [4:0]  cmd_key_base;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_last;
    logic        busy;
    logic        done;
    logic        cmd_err;
`ifdef AES_SEQ_PERF_EN
    logic [15:0] perf_stall_cnt;
`endif

    aes_instr_sequencer #(.NUM_ROUNDS(10), .INSTR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_state_reg (cmd_state_reg),
        .cmd_key_base  (cmd_key_base),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_last    (instr_last),
        .busy          (busy),
        .done          (done),
        .cmd_err       (cmd_err)
`ifdef AES_SEQ_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_cnt   = 0;
    int last_hs_cyc = 0;
    int first_cyc   = 0;
    bit seen_valid  = 0;
    bit prev_stall  = 0;
    logic [31:0] held_instr;
    logic        held_last;
    int rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic push(input logic [31:0] w, input logic l);
        exp_t x;
        x.w = w;
        x.l = l;
        exp_q.push_back(x);
    endtask

    // Expected streams with NUM_ROUNDS = 10
    task automatic push_seq(input logic [1:0] m, input logic [4:0] s, input logic [4:0] b);
        case (m)
            2'd0: for (int i = 1; i <= 10; i++)
                push(mk(7'(i), 5'(b + i - 1), 5'(b + i - 1), 3'b001, 5'(b + i), 7'h63),
                     i == 10);
            2'd1: begin
                push(mk(7'd0, b, s, 3'b001, s, 7'h33), 1'b0);
                for (int r = 1; r <= 9; r++)
                    push(mk(7'd0, 5'(b + r), s, 3'b000, s, 7'h63), 1'b0);
                push(mk(7'd1, 5'(b + 10), s, 3'b000, s, 7'h63), 1'b1);
            end
            2'd2: begin
                push(mk(7'd0, 5'(b + 10), s, 3'b001, s, 7'h33), 1'b0);
                for (int r = 1; r <= 9; r++)
                    push(mk(7'd0, 5'(b + 10 - r), s, 3'b010, s, 7'h63), 1'b0);
                push(mk(7'd1, b, s, 3'b010, s, 7'h63), 1'b1);
            end
            default: ;
        endcase
    endtask

    initial begin
        instr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: instr_ready = 1'b1;
                1: instr_ready = ~instr_ready;
                default: instr_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (instr_valid && !seen_valid) begin
                seen_valid = 1;
                first_cyc  = cyc;
            end
            if (instr_valid && prev_stall) begin
                check("stall_hold_instr", instr, held_instr);
                check("stall_hold_last", 32'(instr_last), 32'(held_last));
            end
            if (instr_valid && instr_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_instr: got %h expected none", instr);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_word", instr, e.w);
                    check("instr_last", 32'(instr_last), 32'(e.l));
                end
            end
            prev_stall = instr_valid && !instr_ready;
            held_instr = instr;
            held_last  = instr_last;
        end
    end

    task automatic issue_cmd(input logic [1:0] m, input logic [4:0] s,
                             input logic [4:0] b, output int t);
        seen_valid = 0;
        hs_cnt     = 0;
        @(posedge clk);
        #1;
        cmd_valid     = 1'b1;
        cmd_mode      = m;
        cmd_state_reg = s;
        cmd_key_base  = b;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        t = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [1:0] m, input int t);
        bit got = 0;
        int dcyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got  = 1;
                dcyc = cyc;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
            return;
        end
        if (m == 2'd3) begin
            check("err_done_cyc", dcyc, t + 1);
            check("err_flag", 32'(cmd_err), 32'd1);
            check("err_no_valid", 32'(seen_valid), 32'd0);
        end else begin
            check("first_valid_cyc", first_cyc, t + 1);
            check("done_cyc", dcyc, last_hs_cyc + 1);
            check("no_err", 32'(cmd_err), 32'd0);
            check("queue_drained", exp_q.size(), 0);
        end
        check("ready_low_finish", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_back", 32'(cmd_ready), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int t;
        bit got;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_mode      = 2'd0;
        cmd_state_reg = 5'd0;
        cmd_key_base  = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_outputs", {instr_valid, instr_last, busy, done, cmd_err}, 32'd0);
        check("rst_instr", instr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Encrypt S=5 B=16 with hand-encoded first/last words
        rdy_mode = 0;
        push(32'h010292B3, 1'b0);
        for (int r = 1; r <= 9; r++) push(32'h000282E3 | (32'(16 + r) << 20), 1'b0);
        push(32'h03A282E3, 1'b1);
        issue_cmd(2'd1, 5'd5, 5'd16, t);
        check("busy_during", 32'(busy), 32'd1);
        wait_done(2'd1, t);

        // Key expand B=0
        push(32'h020010E3, 1'b0);
        for (int i = 2; i <= 9; i++)
            push(mk(7'(i), 5'(i - 1), 5'(i - 1), 3'b001, 5'(i), 7'h63), 1'b0);
        push(32'h14949563, 1'b1);
        issue_cmd(2'd0, 5'd3, 5'd0, t);
        wait_done(2'd0, t);

        // Decrypt with alternating ready
        rdy_mode = 1;
        push_seq(2'd2, 5'd5, 5'd16);
        issue_cmd(2'd2, 5'd5, 5'd16, t);
        wait_done(2'd2, t);

        // Key register wrap
        rdy_mode = 0;
        push_seq(2'd1, 5'd5, 5'd28);
        issue_cmd(2'd1, 5'd5, 5'd28, t);
        wait_done(2'd1, t);

        // Illegal mode
        issue_cmd(2'd3, 5'd7, 5'd9, t);
        wait_done(2'd3, t);

        // Reset after the fourth instruction
        push_seq(2'd1, 5'd5, 5'd16);
        issue_cmd(2'd1, 5'd5, 5'd16, t);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #2;
            if (hs_cnt >= 4) got = 1;
        end
        check("hs4_reached", 32'(got), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_seq(2'd1, 5'd5, 5'd16);
        issue_cmd(2'd1, 5'd5, 5'd16, t);
        wait_done(2'd1, t);

`ifdef AES_SEQ_PERF_EN
        rdy_mode = 2;
        push_seq(2'd1, 5'd5, 5'd16);
        issue_cmd(2'd1, 5'd5, 5'd16, t);
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        wait_done(2'd1, t);
        check("perf_stall_cnt", 32'(perf_stall_cnt), 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_instr_sequencer.md
Name: aes_instr_sequencer

Overview:
- Instruction-stream generator: the encoding counterpart of the control decoder.
- Accepts one high-level AES command (key expansion, block encrypt, block decrypt) and emits the complete sequence of 32-bit encoded instructions the core executes for it.
- Sits between the host command port and the instruction fetch/issue stage.
- Emits R-type fields: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0].

Parameters:
- NUM_ROUNDS, 10, AES round count (10/12/14); keys K0..K(NUM_ROUNDS) occupy consecutive registers.
- INSTR_W, 32, instruction width; only 32 is legal.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_mode  input  2  0=key expand, 1=encrypt, 2=decrypt, 3=illegal
- cmd_state_reg  input  5  register holding the AES state
- cmd_key_base  input  5  register holding K0
- instr_valid  output  1  instr holds a valid instruction
- instr_ready  input  1  issue stage accepts instr
- instr  output  INSTR_W  encoded instruction
- instr_last  output  1  instr is the last of the sequence
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at sequence end
- cmd_err  output  1  one-cycle pulse, coincident with done, for an illegal mode

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0 except cmd_ready=1.
  - Counters 0, state IDLE.
  - Reset mid-sequence abandons the sequence with no done pulse.
- FSM states IDLE, ISSUE, FINISH.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch mode and registers, clear round counter r.
    - Legal mode: go to ISSUE.
    - Illegal mode: go to FINISH with cmd_err flagged.
  - ISSUE: instr_valid=1.
    - instr and instr_last are held stable while instr_ready=0.
    - Each instr_valid&instr_ready handshake increments r.
    - The handshake on the last instruction goes to FINISH.
    - Back-to-back issue has no bubble.
  - FINISH: exactly one cycle. done=1 (plus cmd_err if flagged), cmd_ready=0, then IDLE.
- Latency:
  - Command accepted at cycle T: first instr_valid at T+1.
  - Last handshake at cycle L: done at L+1, cmd_ready=1 again at L+2.
- Sequences; S = cmd_state_reg, B = cmd_key_base; all register arithmetic is 5-bit, modulo 32 (wrap-around is legal, no error):
  - Key expand, NUM_ROUNDS instructions, i=1..NUM_ROUNDS: opcode 1100011, funct3 001, funct7=i (rcon index), rd=B+i, rs1=B+i-1, rs2=B+i-1.
  - Encrypt, NUM_ROUNDS+1 instructions:
    - First: XOR (opcode 0110011, funct3 001, funct7 0), rd=rs1=S, rs2=B.
    - Then rounds r=1..NUM_ROUNDS-1: opcode 1100011, funct3 000, funct7 0, rd=rs1=S, rs2=B+r.
    - Last: same as a round but funct7=0000001, rs2=B+NUM_ROUNDS.
  - Decrypt, NUM_ROUNDS+1 instructions:
    - First: XOR with rs2=B+NUM_ROUNDS.
    - Then rounds r=1..NUM_ROUNDS-1: funct3 010, funct7 0, rs2=B+NUM_ROUNDS-r.
    - Last: funct3 010, funct7=0000001, rs2=B.
- instr_last=1 only on the final instruction of a sequence.
- cmd_valid while busy is ignored; cmd_ready=0 during ISSUE and FINISH.

Optional Feature:
- Macro AES_SEQ_PERF_EN.
- When defined:
  - Adds output perf_stall_cnt (16 bits).
  - Counts cycles with instr_valid&!instr_ready, saturating at 0xFFFF.
  - Cleared on reset and on each command acceptance.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package crypto_isa_pkg holds:
  - opcode enums (AES_CRYPTO=1100011, R_TYPE=0110011);
  - funct3 enums (aesEncryption=000, keyExpandRound=001, aesDecryption=010, XOR=001);
  - FINAL_FUNCT7=7'h01;
  - the cmd_mode enum.
- The control decoder consumes the same package.
- One sub-module, aes_instr_encoder: combinational field packer (funct7, rs2, rs1, funct3, rd, opcode) -> instruction word.

Test Plan:
- Encrypt, S=5, B=16, instr_ready=1:
  - 11 instructions, first 0x010292B3, last 0x03A282E3 with instr_last=1.
  - done at the cycle after the last handshake.
- Key expand, B=0: 10 instructions.
  - Instruction 1 = funct7 1, rd 1, rs1 0, funct3 001, opcode 0x63.
  - Instruction 10 has funct7 10, rd 10.
- Decrypt, S=5, B=16, instr_ready toggled 1/0 every cycle:
  - instr stays stable on stall cycles.
  - rs2 sequence 26, 25..17, 16; final instruction funct3 010, funct7 1.
- Wrap, encrypt with B=28: rs2 sequence 28,29,30,31,0..6 with no error.
- Illegal mode 3: no instr_valid; done and cmd_err pulse together at T+1.
- Reset mid-ISSUE:
  - rst_n low after instruction 4: instr_valid=0 and cmd_ready=1 immediately, with no done pulse.
  - A fresh command afterwards restarts at instruction 1.
  - With AES_SEQ_PERF_EN defined: a 3-cycle stall reads perf_stall_cnt=3.
